// File: rtl/inv_sqrt_nr_core.sv
// Iterative FP32 fast inverse square root: magic-constant seed followed by
// N_ITER Newton-Raphson refinements on a single shared truncating FP32 multiplier.
module inv_sqrt_nr_core #(
  parameter int unsigned N_ITER = 1,
  parameter logic [31:0] MAGIC  = 32'h5f3759df
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] DataIn,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] DataOut,
  output logic        err
);

  typedef enum logic [2:0] {StIdle, StSeed, StMulA, StMulB, StSub, StMulC, StDone} state_e;

  state_e      state_q, state_d;
  logic [31:0] x_q, x_d;
  logic [31:0] y_q, y_d;
  logic [31:0] t_q, t_d;
  logic [1:0]  iter_q, iter_d;
  logic        err_q, err_d;
  logic        special;
  logic [31:0] special_val;

  // Truncating FP32 multiply; operands are assumed normal.
  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic               sgn;
    logic [47:0]        prod;
    logic [22:0]        mant;
    logic signed [10:0] exp;
    sgn  = a[31] ^ b[31];
    prod = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    exp  = $signed({3'b000, a[30:23]}) + $signed({3'b000, b[30:23]}) - 11'sd127;
    if (prod[47]) begin
      mant = 23'(prod >> 24);
      exp  = exp + 11'sd1;
    end else begin
      mant = 23'(prod >> 23);
    end
    if (exp >= 11'sd255) begin
      fp_mul = 32'h7F7FFFFF;
    end else if (exp <= 11'sd0) begin
      fp_mul = 32'h0000_0000;
    end else begin
      fp_mul = {sgn, exp[7:0], mant};
    end
  endfunction

  // d = 1.5 - t/2 in Q1.26; outside h in [0.25, 1.5) the step degrades to d = 1.0.
  function automatic logic [31:0] sub_step(input logic [31:0] t);
    logic [26:0] q;
    logic [26:0] d;
    logic [26:0] dn;
    logic        ok;
    int          p;
    q  = '0;
    ok = 1'b0;
    // Exponent of h is one below t's, so t exponents 126..128 cover h in [0.25, 2).
    if (!t[31]) begin
      case (t[30:23])
        8'd128: begin
          q  = {1'b1, t[22:0], 3'b000};
          ok = ~t[22];
        end
        8'd127: begin
          q  = {1'b0, 1'b1, t[22:0], 2'b00};
          ok = 1'b1;
        end
        8'd126: begin
          q  = {2'b00, 1'b1, t[22:0], 1'b0};
          ok = 1'b1;
        end
        default: ok = 1'b0;
      endcase
    end
    if (!ok) begin
      sub_step = 32'h3F80_0000;
    end else begin
      d = 27'h600_0000 - q;
      p = 0;
      for (int i = 0; i < 27; i++) begin
        if (d[i]) p = i;
      end
      dn       = d << (26 - p);
      sub_step = {1'b0, 8'(101 + p), 23'(dn >> 3)};
    end
  endfunction

  // Classify the registered operand for the special-case shortcut.
  always_comb begin
    special     = 1'b1;
    special_val = 32'h0000_0000;
    if (x_q[30:23] == 8'h00) begin
      special_val = 32'h7F80_0000;
    end else if (x_q[30:23] == 8'hFF && x_q[22:0] != 23'd0) begin
      special_val = 32'h7FC0_0000;
    end else if (x_q[31]) begin
      special_val = 32'h7FC0_0000;
    end else if (x_q[30:23] == 8'hFF) begin
      special_val = 32'h0000_0000;
    end else begin
      special = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else if (ce) begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: if (in_valid) state_d = StSeed;
      StSeed: state_d = (special || N_ITER == 0) ? StDone : StMulA;
      StMulA: state_d = StMulB;
      StMulB: state_d = StSub;
      StSub:  state_d = StMulC;
      StMulC: state_d = (32'(iter_q) + 32'd1 < N_ITER) ? StMulA : StDone;
      StDone: if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath next-state: one multiply or subtract per cycle.
  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    t_d    = t_q;
    iter_d = iter_q;
    err_d  = err_q;
    case (state_q)
      StIdle: if (in_valid) x_d = DataIn;
      StSeed: begin
        iter_d = 2'd0;
        err_d  = special;
        y_d    = special ? special_val : MAGIC - (x_q >> 1);
      end
      StMulA: t_d = fp_mul(x_q, y_q);
      StMulB: t_d = fp_mul(t_q, y_q);
      StSub:  t_d = sub_step(t_q);
      StMulC: begin
        y_d    = fp_mul(y_q, t_q);
        iter_d = iter_q + 2'd1;
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q    <= '0;
      y_q    <= '0;
      t_q    <= '0;
      iter_q <= '0;
      err_q  <= 1'b0;
    end else if (ce) begin
      x_q    <= x_d;
      y_q    <= y_d;
      t_q    <= t_d;
      iter_q <= iter_d;
      err_q  <= err_d;
    end
  end

  // Outputs; in_ready is masked during the reset cycle itself.
  always_comb begin
    in_ready  = (state_q == StIdle) && !rst;
    out_valid = (state_q == StDone);
    DataOut   = y_q;
    err       = err_q;
  end

endmodule

// File: tb/tb_inv_sqrt_nr_core.sv
// Directed bench for inv_sqrt_nr_core: three instances (N_ITER = 0, 1, 2) share
// clock, reset, ce, operand and out_ready; each has its own in_valid.
module tb_inv_sqrt_nr_core;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce;
  logic        out_ready;
  logic [31:0] din;
  logic [2:0]  in_valid;
  logic [2:0]  in_ready;
  logic [2:0]  out_valid;
  logic [2:0]  err;
  logic [31:0] dout [3];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  inv_sqrt_nr_core #(.N_ITER(0), .MAGIC(32'h5f3759df)) u_dut0 (
    .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .DataIn(din), .out_valid(out_valid[0]), .out_ready(out_ready), .DataOut(dout[0]),
    .err(err[0])
  );

  inv_sqrt_nr_core #(.N_ITER(1), .MAGIC(32'h5f3759df)) u_dut1 (
    .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .DataIn(din), .out_valid(out_valid[1]), .out_ready(out_ready), .DataOut(dout[1]),
    .err(err[1])
  );

  inv_sqrt_nr_core #(.N_ITER(2), .MAGIC(32'h5f3759df)) u_dut2 (
    .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .DataIn(din), .out_valid(out_valid[2]), .out_ready(out_ready), .DataOut(dout[2]),
    .err(err[2])
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Normal FP32 bit pattern to real.
  function automatic real fp2real(input logic [31:0] b);
    real m;
    m = 1.0 + real'(b[22:0]) / 8388608.0;
    return (b[31] ? -m : m) * (2.0 ** (real'(b[30:23]) - 127.0));
  endfunction

  // One transaction on instance k, called #1 after a rising edge. Latency counts the
  // accept cycle as 0. stall_at > 0 drops ce for 3 cycles once that latency is reached.
  task automatic run_op(input int k, input logic [31:0] x, input int stall_at,
                        output logic [31:0] res, output logic e, output int lat);
    int guard;
    guard = 0;
    din = x;
    in_valid[k] = 1'b1;
    while (!in_ready[k] && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!in_ready[k]) begin
      in_valid[k] = 1'b0;
      res = '0;
      e   = 1'b0;
      lat = 999;
      return;
    end
    @(posedge clk); #1;
    in_valid[k] = 1'b0;
    lat = 1;
    while (!out_valid[k] && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (lat == stall_at) begin
        ce = 1'b0;
        repeat (3) begin
          @(posedge clk); #1;
          lat++;
        end
        ce = 1'b1;
      end
    end
    res = dout[k];
    e   = err[k];
    if (out_ready && out_valid[k]) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [31:0] res;
    logic        e;
    int          lat;
    int          bad;
    int          n_bad;
    int          n_lat_bad;
    int          n_err_bad;
    logic [31:0] x;
    logic [31:0] spec_in  [3];
    logic [31:0] spec_out [3];
    real         r;
    real         ref_r;

    rst       = 1'b1;
    ce        = 1'b1;
    out_ready = 1'b1;
    din       = '0;
    in_valid  = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_in_ready_low", 32'(in_ready[0]), 32'd0);
    check_eq("rst_out_valid", 32'(out_valid[0]), 32'd0);
    check_eq("rst_dataout", dout[1], 32'h0);
    check_eq("rst_err", 32'(err[1]), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check_eq("post_rst_in_ready", 32'(in_ready[0]), 32'd1);

    // Seed only with backpressure: 4.0 -> 0x3EF759DF
    out_ready = 1'b0;
    run_op(0, 32'h4080_0000, 0, res, e, lat);
    check_eq("n0_seed_4", res, 32'h3EF7_59DF);
    check_eq("n0_err", 32'(e), 32'd0);
    check_eq("n0_latency", 32'(lat), 32'd2);
    bad = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (!out_valid[0] || dout[0] !== 32'h3EF7_59DF || in_ready[0]) bad++;
    end
    check_eq("backpressure_stable", 32'(bad), 32'd0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check_eq("after_xfer_out_valid", 32'(out_valid[0]), 32'd0);
    check_eq("after_xfer_in_ready", 32'(in_ready[0]), 32'd1);

    // One iteration on 1.0 and 4.0
    run_op(1, 32'h3F80_0000, 0, res, e, lat);
    check_eq("n1_one_range", 32'(res >= 32'h3F7F_8000 && res <= 32'h3F80_0000), 32'd1);
    check_eq("n1_one_exact", res, 32'h3F7F_910E);
    check_eq("n1_one_err", 32'(e), 32'd0);
    check_eq("n1_one_latency", 32'(lat), 32'd6);
    run_op(1, 32'h4080_0000, 0, res, e, lat);
    r = fp2real(res) - 0.5;
    check_eq("n1_four_near_half", 32'(r < 0.001 && r > -0.001), 32'd1);
    check_eq("n1_four_exact", res, 32'h3EFF_910E);
    check_eq("n1_four_latency", 32'(lat), 32'd6);

    // Special cases
    spec_in[0] = 32'h0000_0000; spec_out[0] = 32'h7F80_0000;
    spec_in[1] = 32'hBF80_0000; spec_out[1] = 32'h7FC0_0000;
    spec_in[2] = 32'h7F80_0000; spec_out[2] = 32'h0000_0000;
    for (int i = 0; i < 3; i++) begin
      run_op(1, spec_in[i], 0, res, e, lat);
      check_eq($sformatf("special_val_%h", spec_in[i]), res, spec_out[i]);
      check_eq($sformatf("special_err_%h", spec_in[i]), 32'(e), 32'd1);
      check_eq($sformatf("special_lat_%h", spec_in[i]), 32'(lat), 32'd2);
    end

    // ce dropped for 3 cycles while in MUL_B
    run_op(1, 32'h3F80_0000, 3, res, e, lat);
    check_eq("ce_stall_result", res, 32'h3F7F_910E);
    check_eq("ce_stall_latency", 32'(lat), 32'd9);

    // Reset during SUB aborts the calculation
    din = 32'h3F80_0000;
    in_valid[1] = 1'b1;
    @(posedge clk); #1;
    in_valid[1] = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("midrst_out_valid", 32'(out_valid[1]), 32'd0);
    check_eq("midrst_dataout", dout[1], 32'h0);
    check_eq("midrst_err", 32'(err[1]), 32'd0);
    @(posedge clk); #1;
    check_eq("midrst_in_ready", 32'(in_ready[1]), 32'd1);
    bad = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (out_valid[1]) bad++;
    end
    check_eq("midrst_no_output", 32'(bad), 32'd0);
    run_op(1, 32'h3F80_0000, 0, res, e, lat);
    check_eq("midrst_fresh_result", res, 32'h3F7F_910E);
    check_eq("midrst_fresh_latency", 32'(lat), 32'd6);

    // Two iterations over random normal positive operands
    n_bad     = 0;
    n_lat_bad = 0;
    n_err_bad = 0;
    for (int i = 0; i < 1000; i++) begin
      x = {1'b0, 8'($urandom_range(1, 254)), 23'($urandom)};
      run_op(2, x, 0, res, e, lat);
      ref_r = 1.0 / $sqrt(fp2real(x));
      r = (fp2real(res) - ref_r) / ref_r;
      if (r >= 5.0e-6 || r <= -5.0e-6) n_bad++;
      if (lat != 10) n_lat_bad++;
      if (e) n_err_bad++;
    end
    check_eq("n2_relerr_violations", 32'(n_bad), 32'd0);
    check_eq("n2_latency_violations", 32'(n_lat_bad), 32'd0);
    check_eq("n2_err_violations", 32'(n_err_bad), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/inv_sqrt_nr_core.md
Name: inv_sqrt_nr_core

Overview:
- Iterative FP32 fast inverse square root with valid/ready handshakes on input and output.
- Computes the magic-constant seed y0 = MAGIC - (x >> 1).
- Refines the seed with N_ITER Newton-Raphson steps, y' = y*(1.5 - 0.5*x*y*y), on one shared FP32 multiplier.
- Successor to the seed-only init stage; feeds lighting/normalisation datapaths directly.

Parameters:
- N_ITER, 1, Newton iterations after the seed. Legal range 0..3; 0 returns the bare seed.
- MAGIC, 32'h5f3759df, seed constant.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- ce  input  1  clock enable; when low, all state and outputs hold
- in_valid  input  1  DataIn valid
- in_ready  output  1  core can accept an operand
- DataIn  input  32  FP32 operand x
- out_valid  output  1  DataOut valid
- out_ready  input  1  consumer accepts DataOut
- DataOut  output  32  FP32 result, approximately 1/sqrt(x)
- err  output  1  result came from the special-case path; qualified by out_valid

Behaviour:
- Reset: one clk with rst=1 (regardless of ce) forces the following:
  - FSM to IDLE
  - in_ready=0 in that cycle, 1 from the next cycle
  - out_valid=0, DataOut=0, err=0
  - internal x/y/t registers cleared
- Reset mid-operation aborts the calculation with no output.
- Handshake:
  - Accept when in_valid & in_ready & ce.
  - in_ready=1 only in IDLE; the core holds one operand at a time.
  - Output transfer when out_valid & out_ready & ce.
  - DataOut and err are stable while out_valid=1 and out_ready=0.
  - After the output transfer the FSM returns to IDLE, so in_ready rises the next cycle.
- FSM states: IDLE, SEED, MUL_A, MUL_B, SUB, MUL_C, DONE.
  - IDLE to SEED on accept; x is registered.
  - SEED: y = MAGIC - (x >> 1), a 32-bit unsigned subtract with wrap ignored. It also classifies x.
    - Special case: go to DONE.
    - N_ITER=0: go to DONE with DataOut=y.
    - Otherwise: go to MUL_A.
  - MUL_A: t = x*y. SQRT-sized value, so it cannot underflow for normal x.
  - MUL_B: t = t*y (approximately 1).
  - SUB: h = t with exponent decremented by 1, then d = 1.5 - h.
  - MUL_C: y = y*d. If the iteration count is below N_ITER, go to MUL_A; else go to DONE.
  - DONE: out_valid=1, DataOut=y. Hold until transfer, then go to IDLE.
- Latency from accept to out_valid:
  - normal path: 2 + 4*N_ITER cycles (N_ITER=1 gives 6)
  - special-case path: 2 cycles
- Multiplier rules:
  - Sign is the XOR of the operand signs.
  - Exponent is the sum of the exponents minus 127.
  - 24x24 mantissa product, normalised by at most 1 shift, truncated (round toward zero).
  - Exponent overflow saturates to 0x7F7FFFFF; underflow flushes to +0.
- SUB rules:
  - h is converted to unsigned fixed point Q1.26, exact for h in [0.25, 1.5).
  - d = 1.5 - h, renormalised to FP32 and truncated.
  - If h is outside [0.25, 1.5), d is forced to 1.0 (the iteration becomes a no-op).
- Special cases, decided in SEED (err=1, iterations skipped):
  - x = +/-0 or a denormal (exponent 0): DataOut = 0x7F800000 (+Inf).
  - Sign=1 and x nonzero, including -Inf: DataOut = 0x7FC00000 (qNaN).
  - x = +Inf: DataOut = 0x00000000.
  - x = NaN: DataOut = 0x7FC00000.
- ce=0 at any point: the FSM, counters and outputs freeze; no accept and no transfer.
- out_ready may already be 1 on entering DONE; the transfer then happens in the first DONE cycle.

Test Plan:
- Seed only (N_ITER=0): DataIn=0x40800000 (4.0) gives DataOut=0x3EF759DF exactly, err=0, out_valid 2 cycles after accept.
- N_ITER=1: DataIn=0x3F800000 (1.0) gives DataOut in [0x3F7F8000, 0x3F800000] (about 0.99831), out_valid exactly 6 cycles after accept.
  - Same setup with DataIn=0x40800000 gives a result within 0.001 of 0.5.
- N_ITER=2, random normal positive x (1000 vectors): relative error versus the real 1/sqrt(x) is < 5e-6, and latency is always 10 cycles.
- Special cases: DataIn=0x00000000 gives 0x7F800000, err=1. DataIn=0xBF800000 gives 0x7FC00000, err=1. DataIn=0x7F800000 gives 0x00000000, err=1. Each completes 2 cycles after accept.
- Backpressure and ce:
  - Hold out_ready=0 for 5 cycles: DataOut and out_valid are stable and in_ready stays 0.
  - Drop ce for 3 cycles mid-MUL_B: latency stretches by exactly 3 and the result is unchanged.
- Reset mid-iteration (rst=1 in the SUB cycle): the next cycle shows out_valid=0, DataOut=0, err=0, with in_ready=1 the cycle after. A fresh 1.0 operand then completes normally.
